stash_sequencer: RTL and testbench
==================================

# stash_sequencer

Controller that sequences writes and reads of the sample Stash. It accepts capture and step requests from debounced board buttons, fetches one 8-bit sample per capture from a sample source over a ready/valid handshake, and drives the Stash's `sample_in`/`sample_in_valid`/`next_sample` pins. It also provides an auto-scroll mode that steps through stored samples at a fixed period. It sits between the button/debounce logic and the Stash in the lab top level.

## Interface
- `DEPTH`, 5: Stash depth; saturation limit of `stored_count`.
- `SCROLL_PERIOD`, 100_000_000: cycles between auto-scroll steps (1 s at 100 MHz); must be ≥2.
- `TIMEOUT`, 1024: maximum cycles to wait for `src_valid` per capture; must be ≥1.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `capture_req`  in  1  capture button level; the rising edge requests one capture.
- `next_btn`  in  1  step button level; the rising edge requests one step.
- `auto_en`  in  1  auto-scroll enable (level).
- `src_valid`  in  1  source has data.
- `src_data`  in  8  source sample.
- `src_ready`  out  1  sequencer accepts source data.
- `sample_in`  out  8  to Stash `sample_in`.
- `sample_in_valid`  out  1  to Stash; one-cycle write strobe.
- `next_sample`  out  1  to Stash; one-cycle step strobe.
- `stored_count`  out  $clog2(DEPTH+1)  samples written since reset, saturating at DEPTH.
- `busy`  out  1  state ≠ IDLE.
- `timeout`  out  1  one-cycle pulse when a capture is abandoned.

## Operation
- FSM states: IDLE, WAIT_SRC, WRITE, STEP.
- Outputs are Moore, decoded from the state register only:
  - `src_ready` = WAIT_SRC.
  - `sample_in_valid` = WRITE.
  - `next_sample` = STEP.
  - `busy` = not IDLE.
- Edge detectors: `capture_req` and `next_btn` are each registered once. A rising edge sets `cap_pend` or `step_pend` respectively. Pending flags are single-deep, so extra edges while a flag is set merge into it.
- IDLE:
  - If `cap_pend` → WAIT_SRC; clear `cap_pend`; clear the timeout counter.
  - Else if `step_pend` and `stored_count`>0 → STEP; clear `step_pend`.
  - Else if `step_pend` and `stored_count`==0 → clear `step_pend` and stay in IDLE.
  - Capture has priority over step.
- WAIT_SRC:
  - On `src_valid`&`src_ready` → latch `src_data` into the `sample_in` register, then → WRITE.
  - Else increment the timeout counter. When it reaches TIMEOUT-1 without a handshake → IDLE, `timeout` high for one cycle, no write.
- WRITE: lasts one cycle, then → IDLE. `stored_count` increments, saturating at DEPTH. The auto-scroll timer clears.
- STEP: lasts one cycle, then → IDLE.
- Auto-scroll timer:
  - Counts only while `auto_en`=1 and `stored_count`>0.
  - Held at 0 otherwise, and cleared on WRITE.
  - At SCROLL_PERIOD-1 it wraps to 0 and sets `step_pend`.
- Button edges arriving in any state are latched and served later. They are never dropped unless merged.
- `sample_in` holds the last written value between writes.
- `sample_in_valid` and `next_sample` are never high in the same cycle.

## Timing
- Reset (asynchronous, `reset`=0):
  - State → IDLE.
  - All outputs 0: `sample_in`=0, `stored_count`=0.
  - Pending flags, edge registers and counters → 0.
  - Applies mid-operation, including in WAIT_SRC and WRITE. An aborted WRITE does not count.
- Edge registers reset to 0, so a button already high at reset release registers as one edge.
- Capture latency, with the `capture_req` rise sampled at edge k:
  - `cap_pend` is set at k.
  - State is WAIT_SRC after k+1, so `src_ready` is high from k+1.
  - Handshake at edge m → `sample_in_valid` high for exactly the cycle after m, with `sample_in` = data sampled at m.
  - `src_ready` falls after m.
- Step latency, with the `next_btn` rise sampled at edge k in IDLE and nothing else pending: `next_sample` is high for the cycle after k+1.
- Consecutive strobes of any kind are separated by at least one IDLE cycle.
- Timeout: WAIT_SRC lasts exactly TIMEOUT cycles when no `src_valid` arrives; `timeout` is high in the first IDLE cycle.
- Auto-scroll: with no other activity, `next_sample` pulses every SCROLL_PERIOD cycles.

## Test plan
Bench parameters: DEPTH=5, SCROLL_PERIOD=8, TIMEOUT=4.

1. Reset low mid-WAIT_SRC → all outputs 0 immediately. After release, IDLE with `stored_count`=0.
2. Six captures with `src_valid` tied high, `src_data`=0x11..0x66 → six single-cycle `sample_in_valid` pulses carrying 0x11..0x66 in order; `stored_count` ends at 5.
3. `next_btn` pulse with `stored_count`=0 → no `next_sample`. After one capture, a `next_btn` pulse → exactly one `next_sample`, two edges after the rise.
4. Capture with `src_valid`=0 → `src_ready` high for 4 cycles, then one `timeout` pulse, no `sample_in_valid`, `stored_count` unchanged.
5. `capture_req` and `next_btn` rising in the same cycle → write completes first, then `next_sample` after one IDLE cycle. A held button produces only one request.
6. `auto_en`=1 with 2 samples stored → `next_sample` every 8 cycles. A capture mid-period restarts the 8-cycle count from WRITE. `auto_en`=0 → no pulses.

Source files
------------

// File: rtl/stash_sequencer_if.sv
// Sample-source handshake and Stash drive pins shared by the sequencer and its neighbours.
// master = sequencer side, slave = source/Stash side.
interface stash_sequencer_if;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_ready;
  logic [7:0] sample_in;
  logic       sample_in_valid;
  logic       next_sample;

  modport master (
    input  src_valid,
    input  src_data,
    output src_ready,
    output sample_in,
    output sample_in_valid,
    output next_sample
  );

  modport slave (
    output src_valid,
    output src_data,
    input  src_ready,
    input  sample_in,
    input  sample_in_valid,
    input  next_sample
  );
endinterface

// File: rtl/stash_sequencer.sv
// Sequences Stash writes (one fetched sample per capture) and steps (button or auto-scroll).
// All strobes are Moore-decoded from the state register; IDLE separates consecutive strobes.
module stash_sequencer #(
  parameter int unsigned  DEPTH         = 5,
  parameter int unsigned  SCROLL_PERIOD = 100_000_000,
  parameter int unsigned  TIMEOUT       = 1024,
  localparam int unsigned CountW        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_req,
  input  logic              next_btn,
  input  logic              auto_en,
  stash_sequencer_if.master bus,
  output logic [CountW-1:0] stored_count,
  output logic              busy,
  output logic              timeout
);

  localparam int unsigned TimeoutW = $clog2(TIMEOUT + 1);
  localparam int unsigned ScrollW  = $clog2(SCROLL_PERIOD);

  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT - 1);
  localparam logic [ScrollW-1:0]  ScrollLast  = ScrollW'(SCROLL_PERIOD - 1);
  localparam logic [CountW-1:0]   CountMax    = CountW'(DEPTH);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWaitSrc = 2'd1;
  localparam logic [1:0] StWrite   = 2'd2;
  localparam logic [1:0] StStep    = 2'd3;

  logic [1:0]          state_q, state_d;
  logic                cap_q, nxt_q;
  logic                cap_pend_q, cap_pend_d;
  logic                step_pend_q, step_pend_d;
  logic [TimeoutW-1:0] to_cnt_q, to_cnt_d;
  logic [ScrollW-1:0]  scroll_q, scroll_d;
  logic [7:0]          sample_q, sample_d;
  logic [CountW-1:0]   count_q, count_d;
  logic                timeout_q, timeout_d;

  logic cap_rise, nxt_rise, handshake, have_data;
  logic cap_clr, step_clr, scroll_wrap;

  assign cap_rise  = capture_req & ~cap_q;
  assign nxt_rise  = next_btn & ~nxt_q;
  assign handshake = bus.src_valid & (state_q == StWaitSrc);
  assign have_data = (count_q != '0);

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    sample_d  = sample_q;
    timeout_d = 1'b0;
    cap_clr   = 1'b0;
    step_clr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Capture wins over step; a step with nothing stored is consumed silently.
        if (cap_pend_q) begin
          state_d  = StWaitSrc;
          cap_clr  = 1'b1;
          to_cnt_d = '0;
        end else if (step_pend_q) begin
          step_clr = 1'b1;
          if (have_data) begin
            state_d = StStep;
          end
        end
      end
      StWaitSrc: begin
        if (handshake) begin
          sample_d = bus.src_data;
          state_d  = StWrite;
        end else if (to_cnt_q == TimeoutLast) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TimeoutW'(1);
        end
      end
      StWrite: state_d = StIdle;
      StStep:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if ((state_q == StWrite) && (count_q != CountMax)) begin
      count_d = count_q + CountW'(1);
    end
  end

  // A write restarts the scroll period; the timer idles while disabled or empty.
  always_comb begin
    scroll_d    = scroll_q;
    scroll_wrap = 1'b0;
    if ((state_q == StWrite) || !auto_en || !have_data) begin
      scroll_d = '0;
    end else if (scroll_q == ScrollLast) begin
      scroll_d    = '0;
      scroll_wrap = 1'b1;
    end else begin
      scroll_d = scroll_q + ScrollW'(1);
    end
  end

  // New edges win over the clear so a request landing on the service cycle is kept.
  always_comb begin
    cap_pend_d  = cap_rise | (cap_pend_q & ~cap_clr);
    step_pend_d = nxt_rise | scroll_wrap | (step_pend_q & ~step_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cap_q       <= 1'b0;
      nxt_q       <= 1'b0;
      cap_pend_q  <= 1'b0;
      step_pend_q <= 1'b0;
      to_cnt_q    <= '0;
      scroll_q    <= '0;
      sample_q    <= '0;
      count_q     <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_q       <= capture_req;
      nxt_q       <= next_btn;
      cap_pend_q  <= cap_pend_d;
      step_pend_q <= step_pend_d;
      to_cnt_q    <= to_cnt_d;
      scroll_q    <= scroll_d;
      sample_q    <= sample_d;
      count_q     <= count_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.src_ready       = (state_q == StWaitSrc);
  assign bus.sample_in_valid = (state_q == StWrite);
  assign bus.next_sample     = (state_q == StStep);
  assign bus.sample_in       = sample_q;
  assign busy                = (state_q != StIdle);
  assign timeout             = timeout_q;
  assign stored_count        = count_q;

endmodule

// File: tb/tb_stash_sequencer.sv
// Self-checking bench: cycle-level reference model from the behavioural rules, directed
// scenarios for each test-plan item, then randomized button/source/reset traffic.
module tb_stash_sequencer;

  localparam int DEPTH = 5;
  localparam int SP    = 8;
  localparam int TO    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       capture_req = 1'b0;
  logic       next_btn = 1'b0;
  logic       auto_en = 1'b0;
  logic [2:0] stored_count;
  logic       busy;
  logic       timeout;

  stash_sequencer_if bus_if ();

  stash_sequencer #(
    .DEPTH        (DEPTH),
    .SCROLL_PERIOD(SP),
    .TIMEOUT      (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .capture_req (capture_req),
    .next_btn    (next_btn),
    .auto_en     (auto_en),
    .bus         (bus_if),
    .stored_count(stored_count),
    .busy        (busy),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] wr_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase flags, cycles spent waiting, total writes, scroll age.
  bit         m_cap_prev, m_nxt_prev, m_cap_pend, m_step_pend;
  bit         m_waiting, m_writing, m_stepping, m_timeout;
  int         m_wait_cycles, m_writes, m_age;
  logic [7:0] m_data;

  task automatic model_step();
    int cnt;
    bit cap_rise, nxt_rise, fire, cap_clr, step_clr, idle;
    bit n_wait, n_write, n_step, n_to;
    if (reset !== 1'b1) begin
      m_cap_prev = 0; m_nxt_prev = 0; m_cap_pend = 0; m_step_pend = 0;
      m_waiting = 0; m_writing = 0; m_stepping = 0; m_timeout = 0;
      m_wait_cycles = 0; m_writes = 0; m_age = 0; m_data = 8'h00;
      return;
    end
    cnt      = (m_writes > DEPTH) ? DEPTH : m_writes;
    cap_rise = capture_req && !m_cap_prev;
    nxt_rise = next_btn && !m_nxt_prev;
    m_cap_prev = capture_req;
    m_nxt_prev = next_btn;
    fire = 0;
    if (!auto_en || cnt == 0 || m_writing) m_age = 0;
    else begin
      if (m_age % SP == SP - 1) fire = 1;
      m_age++;
    end
    cap_clr = 0; step_clr = 0; n_wait = 0; n_write = 0; n_step = 0; n_to = 0;
    idle = !(m_waiting || m_writing || m_stepping);
    if (m_writing) m_writes++;
    if (m_waiting) begin
      if (bus_if.src_valid === 1'b1) begin
        n_write = 1;
        m_data  = bus_if.src_data;
      end else if (m_wait_cycles >= TO) n_to = 1;
      else begin
        n_wait = 1;
        m_wait_cycles++;
      end
    end else if (idle) begin
      if (m_cap_pend) begin
        n_wait = 1; m_wait_cycles = 1; cap_clr = 1;
      end else if (m_step_pend) begin
        step_clr = 1;
        n_step   = (cnt > 0);
      end
    end
    m_cap_pend  = cap_rise || (m_cap_pend && !cap_clr);
    m_step_pend = nxt_rise || fire || (m_step_pend && !step_clr);
    m_waiting = n_wait; m_writing = n_write; m_stepping = n_step; m_timeout = n_to;
  endtask

  always begin
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    check("src_ready", bus_if.src_ready, m_waiting);
    check("sample_in_valid", bus_if.sample_in_valid, m_writing);
    check("next_sample", bus_if.next_sample, m_stepping);
    check("busy", busy, (m_waiting || m_writing || m_stepping));
    check("timeout", timeout, m_timeout);
    check("stored_count", stored_count, (m_writes > DEPTH) ? DEPTH : m_writes);
    check("sample_in", bus_if.sample_in, m_data);
    if (bus_if.sample_in_valid === 1'b1) wr_log.push_back(bus_if.sample_in);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    capture_req = 1'b0; next_btn = 1'b0; auto_en = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_count", stored_count, 0);
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic capture(input logic [7:0] d);
    @(negedge clk);
    capture_req = 1'b1;
    bus_if.src_data = d;
    @(negedge clk) capture_req = 1'b0;
    tick(4);
  endtask

  task automatic wait_sig(input string tag, input bit want_write, input int limit,
                          output int at);
    at = -1;
    for (int i = 0; i < limit && at < 0; i++) begin
      @(posedge clk);
      #1;
      if ((want_write ? bus_if.sample_in_valid : bus_if.next_sample) === 1'b1) at = cyc;
    end
    check(tag, at >= 0, 1);
  endtask

  initial begin
    int n, rdy, tos, wr, wr_at, st_at, nw, ns, p0, p1, p2, p3, w;
    int unsigned vprob;
    bus_if.src_valid = 1'b0;
    bus_if.src_data  = 8'h00;
    #1 reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    check("init_count", stored_count, 0);

    // 1: reset in the middle of WAIT_SRC
    @(negedge clk) capture_req = 1'b1;
    @(negedge clk) capture_req = 1'b0;
    @(negedge clk);
    check("t1_in_wait", bus_if.src_ready, 1);
    #2 reset = 1'b0;
    #1;
    check("t1_ready0", bus_if.src_ready, 0);
    check("t1_busy0", busy, 0);
    check("t1_sample0", bus_if.sample_in, 0);
    check("t1_count0", stored_count, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("t1_idle", busy, 0);

    // 2: six captures, saturating count
    bus_if.src_valid = 1'b1;
    wr_log.delete();
    for (int i = 1; i <= 6; i++) capture(8'(i * 17));
    check("t2_nwrites", wr_log.size(), 6);
    for (int i = 0; i < 6 && i < wr_log.size(); i++) check("t2_data", wr_log[i], 8'((i + 1) * 17));
    check("t2_count", stored_count, 5);

    // 3: step with nothing stored, then after one capture
    do_reset();
    @(negedge clk) next_btn = 1'b1;
    @(negedge clk) next_btn = 1'b0;
    n = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus_if.next_sample === 1'b1) n++;
    end
    check("t3_no_step", n, 0);
    capture(8'hA5);
    @(negedge clk) next_btn = 1'b1;
    @(posedge clk); #1 check("t3_edge_k", bus_if.next_sample, 0);
    @(posedge clk); #1 check("t3_edge_k1", bus_if.next_sample, 1);
    @(posedge clk); #1 check("t3_edge_k2", bus_if.next_sample, 0);
    @(negedge clk) next_btn = 1'b0;

    // 4: timeout with no source data
    bus_if.src_valid = 1'b0;
    @(negedge clk) capture_req = 1'b1;
    @(negedge clk) capture_req = 1'b0;
    rdy = 0; tos = 0; wr = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus_if.src_ready === 1'b1) rdy++;
      if (timeout === 1'b1) tos++;
      if (bus_if.sample_in_valid === 1'b1) wr++;
    end
    check("t4_ready_cycles", rdy, TO);
    check("t4_timeouts", tos, 1);
    check("t4_writes", wr, 0);
    check("t4_count", stored_count, 1);

    // 5: simultaneous capture and step, buttons held
    do_reset();
    bus_if.src_valid = 1'b1;
    bus_if.src_data  = 8'h5A;
    @(negedge clk);
    capture_req = 1'b1;
    next_btn    = 1'b1;
    wr_at = -1; st_at = -1; nw = 0; ns = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.sample_in_valid === 1'b1) begin nw++; if (wr_at < 0) wr_at = i; end
      if (bus_if.next_sample === 1'b1) begin ns++; if (st_at < 0) st_at = i; end
    end
    @(negedge clk);
    capture_req = 1'b0;
    next_btn    = 1'b0;
    check("t5_write_at", wr_at, 2);
    check("t5_step_at", st_at, 4);
    check("t5_nwrites", nw, 1);
    check("t5_nsteps", ns, 1);

    // 6: auto-scroll period, restart on write, disable
    do_reset();
    bus_if.src_valid = 1'b1;
    capture(8'h01);
    capture(8'h02);
    @(negedge clk) auto_en = 1'b1;
    wait_sig("t6_pulse0", 1'b0, 20, p0);
    wait_sig("t6_pulse1", 1'b0, 20, p1);
    wait_sig("t6_pulse2", 1'b0, 20, p2);
    check("t6_period_a", p1 - p0, SP);
    check("t6_period_b", p2 - p1, SP);
    @(negedge clk) capture_req = 1'b1;
    bus_if.src_data = 8'h03;
    @(negedge clk) capture_req = 1'b0;
    wait_sig("t6_write", 1'b1, 10, w);
    wait_sig("t6_pulse3", 1'b0, 20, p3);
    check("t6_write_at", w - p2, 3);
    check("t6_restart", p3 - p2, 13);
    @(negedge clk) auto_en = 1'b0;
    tick(3);
    n = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus_if.next_sample === 1'b1) n++;
    end
    check("t6_disabled", n, 0);

    // Random traffic, checked cycle by cycle against the model
    vprob = 5;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      reset = 1'b1;
      if (i % 128 == 0) vprob = $urandom_range(0, 9);
      if ($urandom_range(0, 5) == 0) capture_req = ~capture_req;
      if ($urandom_range(0, 5) == 0) next_btn = ~next_btn;
      if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
      bus_if.src_valid = ($urandom_range(0, 9) < vprob);
      bus_if.src_data  = 8'($urandom);
      if ($urandom_range(0, 249) == 0) #2 reset = 1'b0;
    end
    @(negedge clk) reset = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
